// File: rtl/lif_cfg_pkg.sv
// Shared configuration for the LIF neuron parameter loader: sizes, reset-default parameter image, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lif_cfg_pkg;

  localparam int unsigned LIF_NUM_PARAMS = 4;
  localparam int unsigned LIF_PARAM_W    = 8;
  localparam int unsigned LIF_AW         = $clog2(LIF_NUM_PARAMS);

  typedef logic [LIF_PARAM_W-1:0] lif_param_t;

  // Power-on neuron configuration: threshold, leak, weight_a, weight_b.
  localparam lif_param_t LIF_PARAM_DEFAULT [LIF_NUM_PARAMS] = '{8'h30, 8'h02, 8'h04, 8'h01};

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_SHIFT,
    LD_SETTLE
  } lif_ld_state_t;

  // Default for slot k; slots beyond the default image come up as zero.
  function automatic lif_param_t lif_param_default(input int unsigned k);
    lif_param_t v;
    v = '0;
    if (k < LIF_NUM_PARAMS) v = LIF_PARAM_DEFAULT[k[LIF_AW-1:0]];
    return v;
  endfunction

endpackage

// File: rtl/lif_param_bank.sv
// Register file holding the neuron parameter bytes, one write port and a single-bit combinational read port.
// Latency: write lands at the clock edge; read is combinational on (rd_word, rd_pos).
// Backpressure: none; the caller gates wr_en. Addresses outside the bank match no slot and are dropped.
module lif_param_bank
  import lif_cfg_pkg::*;
#(
  parameter int unsigned NUM_PARAMS = LIF_NUM_PARAMS,
  parameter int unsigned PARAM_W    = LIF_PARAM_W,
  localparam int unsigned AW        = $clog2(NUM_PARAMS),
  localparam int unsigned BW        = (PARAM_W > 1) ? $clog2(PARAM_W) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PARAM_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_word,
  input  logic [BW-1:0]      rd_pos,
  output logic               rd_bit
);

  logic [PARAM_W-1:0] param_q [NUM_PARAMS];

  for (genvar k = 0; k < NUM_PARAMS; k++) begin : g_slot
    // Slot k: restore its default on reset, otherwise take a write addressed to it.
    always_ff @(posedge clk) begin
      if (reset) begin
        param_q[k] <= PARAM_W'(lif_param_default(k));
      end else if (wr_en && (wr_addr == AW'(k))) begin
        param_q[k] <= wr_data;
      end
    end
  end

  assign rd_bit = param_q[rd_word][rd_pos];

endmodule

// File: rtl/lif_param_loader.sv
// Serialises the parameter bank to the LIF neuron (MSB first, param 0 first) and waits for its params_ready ack.
// Latency: first frame bit one cycle after the cycle in which start is taken; done/error one cycle after the deciding sample.
// Backpressure: wr_ready low and start ignored (not queued) whenever the loader is not idle.
module lif_param_loader
  import lif_cfg_pkg::*;
#(
  parameter int unsigned NUM_PARAMS    = LIF_NUM_PARAMS,
  parameter int unsigned PARAM_W       = LIF_PARAM_W,
  parameter int unsigned READY_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_PARAMS)-1:0] wr_addr,
  input  logic [PARAM_W-1:0]            wr_data,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [7:0]                    frames_ok,
  output logic                          load_mode,
  output logic                          serial_data,
  input  logic                          params_ready
);

  localparam int unsigned AW = $clog2(NUM_PARAMS);
  localparam int unsigned IW = $clog2(NUM_PARAMS + 1);
  localparam int unsigned BW = (PARAM_W > 1) ? $clog2(PARAM_W) : 1;
  localparam int unsigned TW = $clog2(READY_TIMEOUT + 1);

  lif_ld_state_t state;
  logic [IW-1:0] word_idx;   // parameter currently being shifted; NUM_PARAMS means frame finished
  logic [BW-1:0] bit_idx;    // bits of that parameter already sent
  logic [TW-1:0] tmo_cnt;
  logic          seen_low;   // params_ready observed low since start, so a later high is a fresh ack
  logic          wr_en;
  logic          rd_bit;
  logic [BW-1:0] rd_pos;

  // Writes only land while idle; a write together with start is taken before the first bit is read.
  assign wr_ready = (state == LD_IDLE);
  assign wr_en    = wr_valid && wr_ready;
  assign rd_pos   = BW'(PARAM_W - 1) - bit_idx;

  lif_param_bank #(
    .NUM_PARAMS (NUM_PARAMS),
    .PARAM_W    (PARAM_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_word (word_idx[AW-1:0]),
    .rd_pos  (rd_pos),
    .rd_bit  (rd_bit)
  );

  // Loader FSM: idle -> shift the frame out bit by bit -> settle waiting for a fresh params_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LD_IDLE;
      word_idx    <= '0;
      bit_idx     <= '0;
      tmo_cnt     <= '0;
      seen_low    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      frames_ok   <= 8'd0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if ((state != LD_IDLE) && !params_ready) seen_low <= 1'b1;

      case (state)
        LD_IDLE: begin
          if (start) begin
            state    <= LD_SHIFT;
            word_idx <= '0;
            bit_idx  <= '0;
            seen_low <= 1'b0;
            busy     <= 1'b1;
          end
        end

        LD_SHIFT: begin
          if (word_idx == IW'(NUM_PARAMS)) begin
            state       <= LD_SETTLE;
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            tmo_cnt     <= '0;
          end else begin
            load_mode   <= 1'b1;
            serial_data <= rd_bit;
            if (bit_idx == BW'(PARAM_W - 1)) begin
              bit_idx  <= '0;
              word_idx <= word_idx + IW'(1);
            end else begin
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end

        LD_SETTLE: begin
          tmo_cnt <= tmo_cnt + TW'(1);
          // A fresh ack beats a timeout landing on the same cycle.
          if (seen_low && params_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= LD_IDLE;
            if (frames_ok != 8'hFF) frames_ok <= frames_ok + 8'd1;
          end else if ((tmo_cnt + TW'(1)) == TW'(READY_TIMEOUT)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= LD_IDLE;
          end
        end

        default: begin
          state <= LD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
